// File: rtl/cr_kme_word_packer.sv
// cr_kme_word_packer: packs the 34-bit {sot, eot, word} KME command stream
// into 64-bit beats, tracks frame length and flags framing violations.
module cr_kme_word_packer #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [33:0]      in_data,
    input  logic             in_valid,
    output logic             in_ack,
    output logic [63:0]      out_data,
    output logic             out_sot,
    output logic             out_eot,
    output logic             out_words,
    output logic [LEN_W-1:0] out_len,
    output logic             out_valid,
    input  logic             out_stall,
    output logic             frame_err,
    output logic [31:0]      frame_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_EVEN, S_ODD} state_t;

    state_t             state_q, state_d;
    logic [31:0]        hold_q, hold_d;
    logic               hold_sot_q, hold_sot_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [63:0]        out_data_q, out_data_d;
    logic               out_sot_q, out_sot_d;
    logic               out_eot_q, out_eot_d;
    logic               out_words_q, out_words_d;
    logic [LEN_W-1:0]   out_len_q, out_len_d;
    logic               out_valid_q, out_valid_d;
    logic               frame_err_q, frame_err_d;
    logic [31:0]        frame_cnt_q, frame_cnt_d;

    logic               in_sot, in_eot;
    logic [31:0]        in_word;
    logic               xfer, free, ack, load;
    logic [LEN_W-1:0]   len_inc;
    logic [63:0]        b_data;
    logic               b_sot, b_eot, b_words;
    logic [LEN_W-1:0]   b_len;

    assign in_sot  = in_data[33];
    assign in_eot  = in_data[32];
    assign in_word = in_data[31:0];
    assign xfer    = out_valid_q && !out_stall;
    assign free    = !out_valid_q || !out_stall;
    assign len_inc = (len_q == {LEN_W{1'b1}}) ? len_q : len_q + LEN_W'(1);
    assign in_ack  = ack;

    // Framing state machine: decides ack, held word, and beat to load.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_sot_d = hold_sot_q;
        len_d      = len_q;
        ack        = 1'b0;
        load       = 1'b0;
        frame_err_d = 1'b0;
        b_data     = 64'h0;
        b_sot      = 1'b0;
        b_eot      = 1'b0;
        b_words    = 1'b0;
        b_len      = len_inc;
        if (in_valid) begin
            case (state_q)
                S_IDLE, S_EVEN: begin
                    if (in_sot) begin
                        if (in_eot) begin
                            if (free) begin
                                ack         = 1'b1;
                                load        = 1'b1;
                                b_data      = {32'h0, in_word};
                                b_sot       = 1'b1;
                                b_eot       = 1'b1;
                                b_len       = LEN_W'(1);
                                len_d       = LEN_W'(1);
                                state_d     = S_IDLE;
                                frame_err_d = (state_q == S_EVEN);
                            end
                        end else begin
                            ack         = 1'b1;
                            hold_d      = in_word;
                            hold_sot_d  = 1'b1;
                            len_d       = LEN_W'(1);
                            state_d     = S_ODD;
                            frame_err_d = (state_q == S_EVEN);
                        end
                    end else if (state_q == S_IDLE) begin
                        // Stray word outside a frame is dropped.
                        ack         = 1'b1;
                        frame_err_d = 1'b1;
                    end else if (in_eot) begin
                        if (free) begin
                            ack     = 1'b1;
                            load    = 1'b1;
                            b_data  = {32'h0, in_word};
                            b_eot   = 1'b1;
                            len_d   = len_inc;
                            state_d = S_IDLE;
                        end
                    end else begin
                        ack        = 1'b1;
                        hold_d     = in_word;
                        hold_sot_d = 1'b0;
                        len_d      = len_inc;
                        state_d    = S_ODD;
                    end
                end
                S_ODD: begin
                    if (free) begin
                        load = 1'b1;
                        if (!in_sot) begin
                            ack     = 1'b1;
                            b_data  = {in_word, hold_q};
                            b_sot   = hold_sot_q;
                            b_eot   = in_eot;
                            b_words = 1'b1;
                            len_d   = len_inc;
                            state_d = in_eot ? S_IDLE : S_EVEN;
                        end else begin
                            // Forced close of the held word; a new sot+eot word waits a cycle.
                            frame_err_d = 1'b1;
                            b_data      = {32'h0, hold_q};
                            b_sot       = hold_sot_q;
                            b_eot       = 1'b1;
                            b_len       = len_q;
                            if (in_eot) begin
                                state_d = S_IDLE;
                            end else begin
                                ack        = 1'b1;
                                hold_d     = in_word;
                                hold_sot_d = 1'b1;
                                len_d      = LEN_W'(1);
                                state_d    = S_ODD;
                            end
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output register next-state and frame counter.
    always_comb begin
        out_data_d  = out_data_q;
        out_sot_d   = out_sot_q;
        out_eot_d   = out_eot_q;
        out_words_d = out_words_q;
        out_len_d   = out_len_q;
        out_valid_d = out_valid_q;
        frame_cnt_d = frame_cnt_q + 32'(xfer && out_eot_q);
        if (load) begin
            out_data_d  = b_data;
            out_sot_d   = b_sot;
            out_eot_d   = b_eot;
            out_words_d = b_words;
            out_len_d   = b_len;
            out_valid_d = 1'b1;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hold_q      <= 32'h0;
            hold_sot_q  <= 1'b0;
            len_q       <= '0;
            out_data_q  <= 64'h0;
            out_sot_q   <= 1'b0;
            out_eot_q   <= 1'b0;
            out_words_q <= 1'b0;
            out_len_q   <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_sot_q  <= hold_sot_d;
            len_q       <= len_d;
            out_data_q  <= out_data_d;
            out_sot_q   <= out_sot_d;
            out_eot_q   <= out_eot_d;
            out_words_q <= out_words_d;
            out_len_q   <= out_len_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sot   = out_sot_q;
    assign out_eot   = out_eot_q;
    assign out_words = out_words_q;
    assign out_len   = out_len_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_cr_kme_word_packer.sv
// Directed scoreboard bench for cr_kme_word_packer.
module tb_cr_kme_word_packer;

    typedef struct packed {
        logic [63:0] data;
        logic        sot;
        logic        eot;
        logic        words;
        logic [15:0] len;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [33:0] in_data;
    logic        in_valid;
    logic        in_ack;
    logic [63:0] out_data;
    logic        out_sot, out_eot, out_words, out_valid;
    logic [15:0] out_len;
    logic        out_stall;
    logic        frame_err;
    logic [31:0] frame_cnt;

    beat_t       exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          err_seen = 0;
    int          exp_err = 0;
    logic [31:0] exp_fc = 32'h0;
    logic        ack_seen;
    logic        prev_stalled = 1'b0;
    logic [63:0] prev_data = 64'h0;

    cr_kme_word_packer #(.LEN_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ack(in_ack), .out_data(out_data), .out_sot(out_sot),
        .out_eot(out_eot), .out_words(out_words), .out_len(out_len),
        .out_valid(out_valid), .out_stall(out_stall),
        .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic s, input logic e,
                        input logic w, input logic [15:0] l);
        beat_t b;
        b.data = d; b.sot = s; b.eot = e; b.words = w;
        b.len = e ? l : 16'h0;
        exp_q.push_back(b);
    endtask

    // Negedge sampling: scoreboard pop, stall stability, error pulses.
    task automatic cycle();
        beat_t obs, e;
        @(negedge clk);
        if (frame_err) err_seen++;
        if (out_valid && out_stall && prev_stalled)
            chk("stall_stable", 128'(out_data), 128'(prev_data));
        prev_stalled = out_valid && out_stall;
        prev_data    = out_data;
        if (out_valid && !out_stall) begin
            n_chk++;
            assert (exp_q.size() > 0) else begin
                n_fail++;
                $error("FAIL unexpected_beat observed=%h expected=none", out_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                obs.data = out_data; obs.sot = out_sot; obs.eot = out_eot;
                obs.words = out_words; obs.len = out_eot ? out_len : 16'h0;
                chk("beat", 128'(obs), 128'(e));
                chk("frame_cnt", 128'(frame_cnt), 128'(exp_fc));
                if (e.eot) exp_fc = exp_fc + 32'h1;
            end
        end
        ack_seen = in_valid && in_ack;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic s, input logic e, input logic [31:0] w);
        logic got;
        got = 1'b0;
        in_valid = 1'b1;
        in_data  = {s, e, w};
        for (int n = 0; n < 40; n++) begin
            cycle();
            if (ack_seen) begin
                got = 1'b1;
                break;
            end
        end
        chk("ack_within_budget", 128'(got), 128'(1'b1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 34'h0; out_stall = 1'b0;
        #12;
        chk("reset_outputs",
            128'({out_valid, out_sot, out_eot, out_words, frame_err, in_ack, out_data, out_len, frame_cnt}),
            128'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic 3-word frame.
        push({32'h2222_0002, 32'h1111_0001}, 1'b1, 1'b0, 1'b1, 16'h0);
        push({32'h0, 32'h3333_0003}, 1'b0, 1'b1, 1'b0, 16'd3);
        send(1'b1, 1'b0, 32'h1111_0001);
        send(1'b0, 1'b0, 32'h2222_0002);
        send(1'b0, 1'b1, 32'h3333_0003);
        idle(3);
        chk("frame_cnt_after_first", 128'(frame_cnt), 128'(32'd1));

        // Single-word frame.
        push({32'h0, 32'hA5A5_A5A5}, 1'b1, 1'b1, 1'b0, 16'd1);
        send(1'b1, 1'b1, 32'hA5A5_A5A5);
        idle(3);

        // 4-word frame with a stall holding the first beat.
        push({32'hB000_0001, 32'hB000_0000}, 1'b1, 1'b0, 1'b1, 16'h0);
        push({32'hB000_0003, 32'hB000_0002}, 1'b0, 1'b1, 1'b1, 16'd4);
        send(1'b1, 1'b0, 32'hB000_0000);
        send(1'b0, 1'b0, 32'hB000_0001);
        out_stall = 1'b1;
        send(1'b0, 1'b0, 32'hB000_0002);
        in_valid = 1'b1;
        in_data  = {1'b0, 1'b1, 32'hB000_0003};
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("ack_during_stall", 128'(ack_seen), 128'(1'b0));
        end
        out_stall = 1'b0;
        send(1'b0, 1'b1, 32'hB000_0003);
        idle(3);

        // Stray word in IDLE.
        send(1'b0, 1'b0, 32'hDEAD_BEEF);
        exp_err++;
        idle(3);
        chk("frame_err_stray", 128'(err_seen), 128'(exp_err));

        // sot while a word is held: forced close, then a normal frame.
        push({32'hC000_0001, 32'hC000_0000}, 1'b1, 1'b0, 1'b1, 16'h0);
        push({32'h0, 32'hC000_0002}, 1'b0, 1'b1, 1'b0, 16'd3);
        push({32'hD000_0001, 32'hD000_0000}, 1'b1, 1'b1, 1'b1, 16'd2);
        send(1'b1, 1'b0, 32'hC000_0000);
        send(1'b0, 1'b0, 32'hC000_0001);
        send(1'b0, 1'b0, 32'hC000_0002);
        send(1'b1, 1'b0, 32'hD000_0000);
        exp_err++;
        send(1'b0, 1'b1, 32'hD000_0001);
        idle(3);
        chk("frame_err_odd_sot", 128'(err_seen), 128'(exp_err));

        // Held sot word closed by a sot+eot word that is deferred one cycle.
        push({32'h0, 32'hE000_0000}, 1'b1, 1'b1, 1'b0, 16'd1);
        push({32'h0, 32'hF000_0000}, 1'b1, 1'b1, 1'b0, 16'd1);
        send(1'b1, 1'b0, 32'hE000_0000);
        send(1'b1, 1'b1, 32'hF000_0000);
        exp_err++;
        idle(3);
        chk("frame_err_deferred", 128'(err_seen), 128'(exp_err));

        // 70000-word frame: length saturates.
        for (int k = 0; k < 35000; k++)
            push({32'(2 * k + 1), 32'(2 * k)}, k == 0, k == 34999, 1'b1, 16'hFFFF);
        for (int i = 0; i < 70000; i++)
            send(i == 0, i == 69999, 32'(i));
        idle(3);
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        chk("frame_cnt_before_reset", 128'(frame_cnt), 128'(exp_fc));

        // Async reset mid-frame with a stalled beat pending.
        out_stall = 1'b1;
        send(1'b1, 1'b0, 32'h7000_0000);
        send(1'b0, 1'b0, 32'h7000_0001);
        send(1'b0, 1'b0, 32'h7000_0002);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            128'({out_valid, out_sot, out_eot, out_words, frame_err, in_ack, out_data, out_len, frame_cnt}),
            128'(0));
        exp_fc = 32'h0;
        prev_stalled = 1'b0;
        out_stall = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        push({32'h0, 32'h5A5A_0001}, 1'b1, 1'b1, 1'b0, 16'd1);
        send(1'b1, 1'b1, 32'h5A5A_0001);
        idle(3);
        chk("frame_cnt_after_reset", 128'(frame_cnt), 128'(32'd1));
        chk("final_queue_empty", 128'(exp_q.size()), 128'(0));
        chk("frame_err_total", 128'(err_seen), 128'(exp_err));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
